disp_chan_sched: RTL
====================

// Module: disp_chan_sched
// PURPOSE
//  Sequencer for the 8-channel 32-bit display multiplexer. It drives the mux channel select (Test) and EN.
//  Auto mode: steps through enabled channels, dwelling a programmable number of cycles on each.
//  Manual mode: follows a switch-selected channel.
//  Every new selection is announced to the downstream 7-seg shifter through a valid/ready handshake.
// PARAMETERS
//  DWELL_W     24   width of dwell counter and dwell input
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  en_in      in   1        global enable; low = scheduler idles
//  mode       in   1        0 = auto rotate, 1 = manual
//  man_sel    in   3        manual channel select (used when mode=1)
//  ch_mask    in   8        auto-mode channel enable, bit i = channel i
//  dwell      in   DWELL_W  auto-mode dwell cycles per channel (0 treated as 1)
//  upd_ready  in   1        downstream shifter ready to latch Disp_num
//  Test       out  3        channel select to the multiplexer
//  EN         out  1        multiplexer enable, registered; high when not IDLE
//  upd_valid  out  1        new selection present on the mux outputs
//  wrap       out  1        1-cycle pulse when auto sequence wraps highest->lowest enabled
// BEHAVIOUR
//  Reset: state=IDLE, Test=0, EN=0, upd_valid=0, wrap=0, dwell counter=0.
//  States are IDLE, SEND and DWELL. All outputs are registered.
//  IDLE -> SEND: requires en_in=1 and either (mode=0 and ch_mask!=0) or mode=1.
//   On this transition Test loads the lowest enabled channel (auto) or man_sel (manual).
//  SEND: upd_valid=1 and Test is held stable.
//   A transfer occurs on the cycle where upd_valid and upd_ready are both 1.
//   On transfer: upd_valid drops next cycle, counter loads max(dwell,1), state -> DWELL.
//   upd_valid never deasserts before a transfer. en_in, mode and mask changes are deferred until it completes.
//  DWELL, auto mode: counter decrements each cycle.
//   At count==1, Test loads the next enabled channel above the current one, wrapping 7->0 and skipping masked bits; state -> SEND.
//   If the current channel is the only one enabled, it is re-sent.
//   wrap pulses together with the Test load when the new channel is lower than or equal to the old one.
//  DWELL, manual mode: counter is ignored.
//   When man_sel != Test, Test loads man_sel and state -> SEND. Otherwise the block stays in DWELL.
//  Mode change while in DWELL takes effect next cycle; auto resumes from the current Test.
//  en_in=0, or ch_mask=0 in auto mode, while in DWELL: -> IDLE next cycle. EN drops on entry; Test keeps its value.
//  Mask bit of the current channel cleared mid-dwell: the dwell completes, then the block advances normally.
//  Latency: IDLE->upd_valid 1 cycle; transfer->next upd_valid = max(dwell,1)+1 cycles in auto mode.
//  Reset mid-handshake: upd_valid clears asynchronously and no transfer is counted.
// CONFIGURATION
//  DISP_SCHED_PAUSE_EN defined: adds input port `pause` (1 bit).
//   While pause=1 in DWELL, the counter freezes and manual reselect is suppressed.
//   pause has no effect in SEND or IDLE.
//  Undefined: no pause port; the counter always runs.
// STRUCTURE
//  Package disp_sched_pkg holds:
//   - state encoding constants (IDLE=2'd0, SEND=2'd1, DWELL=2'd2)
//   - NCH=8 and SEL_W=3
//  Sub-module disp_next_ch: combinational rotate-priority finder.
//   Inputs: cur[2:0], mask[7:0]. Outputs: nxt[2:0], wrapped.
//   Instantiated once, for the DWELL->SEND advance.
// TESTING
//  1. Auto mode, mask=8'hFF, dwell=3, upd_ready=1 -> Test steps 0,1,...,7,0 with upd_valid every 4 cycles; wrap pulses on 7->0.
//  2. mask=8'b1010_0100, dwell=2 -> Test sequence 2,5,7,2,...; wrap on 7->2; channels 0,1,3,4,6 never appear.
//  3. upd_ready held 0 for 10 cycles in SEND -> upd_valid and Test stay stable; the transfer happens on the cycle ready rises.
//  4. Manual mode, man_sel 3->6 -> one upd_valid with Test=6; an unchanged man_sel produces no further upd_valid.
//  5. en_in dropped mid-DWELL -> IDLE next cycle, EN=0; reasserting en_in gives upd_valid 1 cycle later with the lowest enabled channel.
//  6. rst pulsed while upd_valid=1 -> all outputs return to reset values immediately; mask=1 (single channel) then re-sends channel 0 each dwell with wrap set.

Source files
------------

// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display channel scheduler.
// Holds the FSM state encoding, channel count and a lowest-channel helper.
package disp_sched_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DWELL = 2'd2
    } state_e;

    // Lowest set bit of the mask; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_ch(input logic [NCH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_next_ch.sv
// Rotate-priority finder: next enabled channel strictly above cur, wrapping.
// Ports: cur (current channel), mask (enables) -> nxt, wrapped (nxt <= cur).
module disp_next_ch
    import disp_sched_pkg::*;
(
    input  logic [SEL_W-1:0] cur,
    input  logic [NCH-1:0]   mask,
    output logic [SEL_W-1:0] nxt,
    output logic             wrapped
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Offset NCH lands back on cur, so a lone enabled channel re-selects itself.
    always_comb begin
        nxt     = cur;
        found   = 1'b0;
        idx     = '0;
        wrapped = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrapped = found && (nxt <= cur);
    end

endmodule

// File: rtl/disp_chan_sched.sv
// Channel sequencer for the 8-channel display mux (auto rotate / manual).
// Ports: clk, rst (async high), en_in, mode, man_sel, ch_mask, dwell,
//   upd_ready, [pause when DISP_SCHED_PAUSE_EN] -> Test, EN, upd_valid, wrap.
module disp_chan_sched
    import disp_sched_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DISP_SCHED_PAUSE_EN
    input  logic               pause,
`endif
    input  logic               en_in,
    input  logic               mode,
    input  logic [SEL_W-1:0]   man_sel,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               upd_ready,
    output logic [SEL_W-1:0]   Test,
    output logic               EN,
    output logic               upd_valid,
    output logic               wrap
);

    state_e             state_q;
    logic [SEL_W-1:0]   test_q;
    logic               en_q;
    logic               valid_q;
    logic               wrap_q;
    logic [DWELL_W-1:0] cnt_q;

    logic [SEL_W-1:0]   nxt_d;
    logic               wrapped_d;
    logic [DWELL_W-1:0] dwell_d;
    logic               hold_d;

`ifdef DISP_SCHED_PAUSE_EN
    assign hold_d = pause;
`else
    assign hold_d = 1'b0;
`endif

    // A dwell of zero behaves like one cycle.
    assign dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;

    disp_next_ch u_next (
        .cur     (test_q),
        .mask    (ch_mask),
        .nxt     (nxt_d),
        .wrapped (wrapped_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            test_q  <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en_in && (mode || (ch_mask != '0))) begin
                        test_q  <= mode ? man_sel : lowest_ch(ch_mask);
                        valid_q <= 1'b1;
                        en_q    <= 1'b1;
                        state_q <= SEND;
                    end
                end
                // Inputs other than upd_ready are ignored until the transfer.
                SEND: begin
                    if (upd_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= dwell_d;
                        state_q <= DWELL;
                    end
                end
                DWELL: begin
                    if (!en_in || (!mode && (ch_mask == '0))) begin
                        en_q    <= 1'b0;
                        state_q <= IDLE;
                    end else if (mode) begin
                        if (!hold_d && (man_sel != test_q)) begin
                            test_q  <= man_sel;
                            valid_q <= 1'b1;
                            state_q <= SEND;
                        end
                    end else if (!hold_d) begin
                        if (cnt_q <= DWELL_W'(1)) begin
                            test_q  <= nxt_d;
                            wrap_q  <= wrapped_d;
                            valid_q <= 1'b1;
                            state_q <= SEND;
                        end else begin
                            cnt_q <= cnt_q - DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Test      = test_q;
    assign EN        = en_q;
    assign upd_valid = valid_q;
    assign wrap      = wrap_q;

endmodule
